// File: rtl/segment_decoder_monitor.sv
// Decodes the tens/units 7-segment buses back into a 6-bit count once stable.
// Optional STEP_CHECK_EN macro adds a countdown sequence check on step_err.
module segment_decoder_monitor #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_a,
  input  logic [6:0] seg_b,
  output logic [5:0] count_value,
  output logic       value_valid,
  output logic       value_stb,
  output logic       decode_err,
  output logic       step_err
);

  typedef enum logic {StSettle, StHeld} state_e;

  localparam logic [3:0] CntMax = 4'(STABLE_CYCLES - 1);

  // Returns {legal, digit}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: seg_decode = {1'b1, 4'd0};
      7'b0110000: seg_decode = {1'b1, 4'd1};
      7'b1101101: seg_decode = {1'b1, 4'd2};
      7'b1111001: seg_decode = {1'b1, 4'd3};
      7'b0110011: seg_decode = {1'b1, 4'd4};
      7'b1011011: seg_decode = {1'b1, 4'd5};
      7'b1011111: seg_decode = {1'b1, 4'd6};
      7'b1110000: seg_decode = {1'b1, 4'd7};
      7'b1111111: seg_decode = {1'b1, 4'd8};
      7'b1111011: seg_decode = {1'b1, 4'd9};
      default:    seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  logic [6:0] samp_a_q, samp_b_q;
  logic       first_q;
  logic [3:0] cnt_q, cnt_d;
  state_e     state_q, state_d;
  logic       changed, accept;
  logic [4:0] dec_a, dec_b;
  logic [6:0] sum;
  logic       legal;
  logic [5:0] count_value_q;
  logic       value_valid_q, value_stb_q, decode_err_q;

  // The incoming sample is compared against the registered previous one.
  assign changed = first_q || ({seg_a, seg_b} != {samp_a_q, samp_b_q});
  assign accept  = (state_q == StSettle) && !changed && (cnt_q == CntMax);

  assign dec_a = seg_decode(samp_a_q);
  assign dec_b = seg_decode(samp_b_q);
  assign sum   = 7'(dec_a[3:0]) * 7'd10 + 7'(dec_b[3:0]);
  assign legal = dec_a[4] && dec_b[4] && (sum <= 7'd63);

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (changed) begin
      cnt_d   = 4'd0;
      state_d = StSettle;
    end else begin
      if (cnt_q != CntMax) cnt_d = cnt_q + 4'd1;
      if (accept) state_d = StHeld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a_q      <= 7'd0;
      samp_b_q      <= 7'd0;
      first_q       <= 1'b1;
      cnt_q         <= 4'd0;
      state_q       <= StSettle;
      count_value_q <= 6'd0;
      value_valid_q <= 1'b0;
      value_stb_q   <= 1'b0;
      decode_err_q  <= 1'b0;
    end else begin
      samp_a_q    <= seg_a;
      samp_b_q    <= seg_b;
      first_q     <= 1'b0;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      value_stb_q <= accept && legal;
      if (changed) value_valid_q <= 1'b0;
      else if (accept) value_valid_q <= legal;
      if (accept) begin
        decode_err_q <= !legal;
        if (legal) count_value_q <= sum[5:0];
      end
    end
  end

  assign count_value = count_value_q;
  assign value_valid = value_valid_q;
  assign value_stb   = value_stb_q;
  assign decode_err  = decode_err_q;

`ifdef STEP_CHECK_EN
  logic [5:0] prev_q;
  logic       prev_valid_q;
  logic       step_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= 6'd0;
      prev_valid_q <= 1'b0;
      step_err_q   <= 1'b0;
    end else begin
      step_err_q <= 1'b0;
      if (accept && legal) begin
        // A zero previous value is a countdown reload: anything may follow.
        step_err_q   <= prev_valid_q && (prev_q != 6'd0) && (sum[5:0] != prev_q - 6'd1);
        prev_q       <= sum[5:0];
        prev_valid_q <= 1'b1;
      end
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: doc/segment_decoder_monitor.md
Name: segment_decoder_monitor

Overview:
- Receive-side counterpart of the count-to-7-segment encoder.
- Samples the two 7-segment digit buses (tens and units), waits for the patterns to be stable, and decodes them back into a 6-bit count.
- Flags illegal or out-of-range patterns.
- Used as an on-chip/bench monitor on the traffic-light countdown display path to confirm that what is driven to the display matches the counter.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical samples required before a pattern is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- seg_a  input  7  tens-digit segments, bit6=a … bit0=g, active-high
- seg_b  input  7  units-digit segments, same bit order
- count_value  output  6  last accepted decoded value, tens*10+units
- value_valid  output  1  high while the current stable pattern decoded legally
- value_stb  output  1  one-cycle pulse when a new legal value is accepted
- decode_err  output  1  high after an illegal or out-of-range pattern is accepted
- step_err  output  1  sequence-check error pulse; tied 0 unless STEP_CHECK_EN

Behaviour:
- Segment legality table: the only legal patterns are
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other pattern, including blank 0000000, is illegal.
- Input stage: seg_a/seg_b are registered once (samp_a/samp_b) every cycle.
- Stability counter (width 4):
  - Resets to 0 when the new sample differs from the previous sample, or on the first sample after reset.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- State machine, SETTLE / HELD:
  - SETTLE → HELD when the counter equals STABLE_CYCLES-1 and the sample is unchanged. This is the acceptance event, and it occurs once only.
  - For STABLE_CYCLES=1, the first new sample is accepted at the next edge.
  - HELD → SETTLE on any sample change.
  - HELD stays HELD while the sample is unchanged; there is no re-acceptance.
- Acceptance, legal case: both digits legal and tens*10+units ≤ 63.
  - count_value is updated, value_valid=1, value_stb=1 for exactly one cycle, decode_err=0.
- Acceptance, error case: either digit illegal, or value > 63 (tens digit 7–9, or 6 with units ≥ 4).
  - decode_err=1, value_valid=0, count_value holds its last good value, no value_stb.
- Arithmetic: tens*10+units is computed at 7 bits before the ≤ 63 check; only bits [5:0] are loaded into count_value.
- Latency: pattern present at the ports before edge k and held → sampled at edge k → outputs updated at edge k+STABLE_CYCLES. Total latency is STABLE_CYCLES+1 edges from the port change.
- On a sample change (state returns to SETTLE):
  - value_valid deasserts the following edge.
  - count_value holds.
  - decode_err is sticky until the next legal acceptance.
- Glitch handling: a change shorter than STABLE_CYCLES samples is never accepted. On return to the old pattern the full stability count restarts, and the old pattern is re-accepted (value_stb pulses again).
- Reset values:
  - Outputs: count_value=0, value_valid=0, value_stb=0, decode_err=0, step_err=0.
  - Internal: samp=0, counter=0, state=SETTLE.
  - Reset mid-settle discards partial stability; counting restarts from the first post-reset sample.

Optional Feature:
- Macro name: STEP_CHECK_EN.
- Defined:
  - Tracks the previous accepted legal value (prev_valid flag, cleared by reset).
  - On each legal acceptance with prev_valid=1, the new value must be prev-1, or, if prev==0, any value (countdown reload).
  - Otherwise step_err pulses for one cycle, aligned with value_stb.
  - Illegal acceptances do not update prev.
- Undefined: step_err is constant 0 and no previous-value storage is built.

Test Plan:
- Reset, then hold seg_a=1111110 (0), seg_b=0110011 (4) with STABLE_CYCLES=4 → value_stb high exactly one cycle, 5 edges after the pattern is applied; count_value=4, value_valid=1, decode_err=0.
- Drive 25 (1101101/1011011), then a 2-cycle glitch to 8 units, then back to 25 → no acceptance of 28; value_valid drops; 25 is re-accepted with one value_stb; count_value=25.
- Drive tens=7 (1110000), units=0 → decode_err=1, value_valid=0, count_value keeps its prior 25, no value_stb.
- Drive units=0000000 (blank) → decode_err=1; then drive legal 63 (1011111/1111001) → decode_err=0, count_value=63, value_stb pulse.
- Assert rst for one cycle at counter=2 while a new pattern is settling → all outputs 0 the next cycle; acceptance occurs STABLE_CYCLES edges after the first post-reset sample.
- With STEP_CHECK_EN: accept 10, 9, 7 → step_err pulses with the 7; accept 0 then 30 → no step_err.
